// File: rtl/aead_pkg.sv
// Shared definitions for the AEAD MAC formatter: sizes, FSM encoding, job record
// and small helpers for block counts, padding and the length block.
package aead_pkg;

  localparam int LEN_W  = 32;
  localparam int BLK_B  = 16;
  localparam int BLK_W  = 8 * BLK_B;
  localparam int CNT_W  = 5;
  localparam int NBLK_W = LEN_W - 3;

  localparam int LEN_AAD_LSB = 0;
  localparam int LEN_CT_LSB  = 64;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_START = 3'd1;
  localparam logic [2:0] ST_KEY_S = 3'd2;
  localparam logic [2:0] ST_AAD   = 3'd3;
  localparam logic [2:0] ST_CT    = 3'd4;
  localparam logic [2:0] ST_LEN   = 3'd5;
  localparam logic [2:0] ST_WDONE = 3'd6;

  typedef struct packed {
    logic [LEN_W-1:0]  len_aad;
    logic [LEN_W-1:0]  len_ct;
    logic [NBLK_W-1:0] na;
    logic [NBLK_W-1:0] nc;
  } job_t;

  // Widened by one bit so a length near 2^32 still rounds up correctly.
  function automatic logic [NBLK_W-1:0] n_blocks(input logic [LEN_W-1:0] len);
    logic [LEN_W:0] sum;
    sum = {1'b0, len} + (LEN_W+1)'(BLK_B - 1);
    return sum[LEN_W:4];
  endfunction

  function automatic logic [LEN_W+1:0] msg_bytes(input logic [NBLK_W-1:0] na,
                                                 input logic [NBLK_W-1:0] nc);
    logic [LEN_W+1:0] blocks;
    blocks = (LEN_W+2)'(na) + (LEN_W+2)'(nc) + (LEN_W+2)'(1);
    return blocks << 4;
  endfunction

  function automatic logic [CNT_W-1:0] last_cnt(input logic [LEN_W-1:0] len);
    return (len[3:0] == 4'd0) ? CNT_W'(BLK_B) : {1'b0, len[3:0]};
  endfunction

  function automatic logic [BLK_W-1:0] len_block(input logic [LEN_W-1:0] len_aad,
                                                 input logic [LEN_W-1:0] len_ct);
    logic [BLK_W-1:0] blk;
    blk = '0;
    blk[LEN_AAD_LSB +: LEN_W] = len_aad;
    blk[LEN_CT_LSB +: LEN_W]  = len_ct;
    return blk;
  endfunction

endpackage

// File: rtl/aead_mac_fmt_if.sv
// Block-stream bus of the MAC formatter: upstream payload handshake on one side,
// Poly1305 tag engine start/request/enable protocol on the other.
interface aead_mac_fmt_if;
  import aead_pkg::*;

  logic             o_drdy;
  logic             i_dvld;
  logic [BLK_W-1:0] i_data;

  logic             o_start;
  logic [BLK_W-1:0] o_msg;
  logic [LEN_W-1:0] o_len_msg;
  logic             o_en_msg;
  logic             i_rqst_msg;
  logic [BLK_W-1:0] i_tag;
  logic             i_done;

  modport master (
    output o_drdy, o_start, o_msg, o_len_msg, o_en_msg,
    input  i_dvld, i_data, i_rqst_msg, i_tag, i_done
  );

  modport slave (
    input  o_drdy, o_start, o_msg, o_len_msg, o_en_msg,
    output i_dvld, i_data, i_rqst_msg, i_tag, i_done
  );
endinterface

// File: rtl/blk_mask.sv
// Zeroes every byte of a block at or above a valid-byte count (1..BLK_B).
module blk_mask
  import aead_pkg::*;
(
  input  logic [CNT_W-1:0] i_cnt,
  input  logic [BLK_W-1:0] i_data,
  output logic [BLK_W-1:0] o_data
);

  genvar gi;
  generate
    for (gi = 0; gi < BLK_B; gi++) begin : g_byte
      localparam logic [CNT_W-1:0] BYTE_IDX = CNT_W'(gi);
      assign o_data[8*gi +: 8] = (BYTE_IDX < i_cnt) ? i_data[8*gi +: 8] : 8'h00;
    end
  endgenerate

endmodule

// File: rtl/aead_mac_fmt.sv
// Formats the Poly1305 MAC input (key r, key s, padded AAD, padded CT, lengths)
// for the tag engine and hands the finished tag back to the AEAD controller.
module aead_mac_fmt
  import aead_pkg::*;
(
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_start,
  input  logic [2*BLK_W-1:0] i_otk,
  input  logic [LEN_W-1:0]   i_len_aad,
  input  logic [LEN_W-1:0]   i_len_ct,
  aead_mac_fmt_if.master     bus,
  output logic [BLK_W-1:0]   o_tag,
  output logic               o_done,
  output logic               o_busy,
  output logic               o_err
);

  logic [2:0]        state_reg;
  logic              rqst_q_reg;
  job_t              job_reg;
  logic [BLK_W-1:0]  s_reg;
  logic [NBLK_W-1:0] cnt_reg;
  logic              drdy_reg;
  logic              start_reg;
  logic              en_reg;
  logic [BLK_W-1:0]  msg_reg;
  logic [LEN_W-1:0]  len_msg_reg;
  logic [BLK_W-1:0]  tag_reg;
  logic              done_reg;
  logic              busy_reg;
  logic              err_reg;

  logic              rqst_edge;
  logic [NBLK_W-1:0] na_in;
  logic [NBLK_W-1:0] nc_in;
  logic [LEN_W+1:0]  msg_bytes_in;
  logic              len_ovf;
  logic [LEN_W-1:0]  seg_len;
  logic [CNT_W-1:0]  keep_cnt;
  logic [BLK_W-1:0]  data_masked;
  logic [2:0]        seg_state_next;
  logic [NBLK_W-1:0] seg_cnt_next;

  assign rqst_edge    = bus.i_rqst_msg & ~rqst_q_reg;
  assign na_in        = n_blocks(i_len_aad);
  assign nc_in        = n_blocks(i_len_ct);
  assign msg_bytes_in = msg_bytes(na_in, nc_in);
  assign len_ovf      = |msg_bytes_in[LEN_W+1:LEN_W];

  // Only the final block of a segment can be partial.
  assign seg_len  = (state_reg == ST_AAD) ? job_reg.len_aad : job_reg.len_ct;
  assign keep_cnt = (cnt_reg == NBLK_W'(1)) ? last_cnt(seg_len) : CNT_W'(BLK_B);

  blk_mask u_blk_mask (
    .i_cnt  (keep_cnt),
    .i_data (bus.i_data),
    .o_data (data_masked)
  );

  // Next non-empty segment after the current one; empty segments are skipped.
  always_comb begin
    seg_state_next = ST_LEN;
    seg_cnt_next   = '0;
    if (state_reg == ST_KEY_S && job_reg.na != '0) begin
      seg_state_next = ST_AAD;
      seg_cnt_next   = job_reg.na;
    end else if (state_reg != ST_CT && job_reg.nc != '0) begin
      seg_state_next = ST_CT;
      seg_cnt_next   = job_reg.nc;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_reg   <= ST_IDLE;
      rqst_q_reg  <= 1'b0;
      job_reg     <= '0;
      s_reg       <= '0;
      cnt_reg     <= '0;
      drdy_reg    <= 1'b0;
      start_reg   <= 1'b0;
      en_reg      <= 1'b0;
      msg_reg     <= '0;
      len_msg_reg <= '0;
      tag_reg     <= '0;
      done_reg    <= 1'b0;
      busy_reg    <= 1'b0;
      err_reg     <= 1'b0;
    end else begin
      rqst_q_reg <= bus.i_rqst_msg;
      start_reg  <= 1'b0;
      en_reg     <= 1'b0;
      done_reg   <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (i_start) begin
            if (len_ovf) begin
              err_reg <= 1'b1;
            end else begin
              err_reg     <= 1'b0;
              busy_reg    <= 1'b1;
              job_reg     <= '{len_aad: i_len_aad, len_ct: i_len_ct, na: na_in, nc: nc_in};
              s_reg       <= i_otk[2*BLK_W-1:BLK_W];
              msg_reg     <= i_otk[BLK_W-1:0];
              len_msg_reg <= msg_bytes_in[LEN_W-1:0];
              start_reg   <= 1'b1;
              state_reg   <= ST_START;
            end
          end
        end
        ST_START: state_reg <= ST_KEY_S;
        ST_KEY_S: begin
          if (rqst_edge) begin
            msg_reg   <= s_reg;
            en_reg    <= 1'b1;
            state_reg <= seg_state_next;
            cnt_reg   <= seg_cnt_next;
          end
        end
        ST_AAD, ST_CT: begin
          if (!drdy_reg) begin
            if (rqst_edge) drdy_reg <= 1'b1;
          end else begin
            if (rqst_edge) err_reg <= 1'b1;
            if (bus.i_dvld) begin
              drdy_reg <= 1'b0;
              msg_reg  <= data_masked;
              en_reg   <= 1'b1;
              if (cnt_reg == NBLK_W'(1)) begin
                state_reg <= seg_state_next;
                cnt_reg   <= seg_cnt_next;
              end else begin
                cnt_reg <= cnt_reg - NBLK_W'(1);
              end
            end
          end
        end
        ST_LEN: begin
          if (rqst_edge) begin
            msg_reg   <= len_block(job_reg.len_aad, job_reg.len_ct);
            en_reg    <= 1'b1;
            state_reg <= ST_WDONE;
          end
        end
        ST_WDONE: begin
          if (rqst_edge) err_reg <= 1'b1;
          if (bus.i_done) begin
            tag_reg   <= bus.i_tag;
            done_reg  <= 1'b1;
            busy_reg  <= 1'b0;
            state_reg <= ST_IDLE;
          end
        end
        default: state_reg <= ST_IDLE;
      endcase
    end
  end

  assign bus.o_drdy    = drdy_reg;
  assign bus.o_start   = start_reg;
  assign bus.o_msg     = msg_reg;
  assign bus.o_len_msg = len_msg_reg;
  assign bus.o_en_msg  = en_reg;
  assign o_tag         = tag_reg;
  assign o_done        = done_reg;
  assign o_busy        = busy_reg;
  assign o_err         = err_reg;

endmodule

// File: tb/tb_aead_mac_fmt.sv
// Directed bench for aead_mac_fmt: byte-level model of the MAC input stream,
// emulated tag engine and upstream buffer, per-cycle output comparison.
`timescale 1ns/1ps
module tb_aead_mac_fmt;
  import aead_pkg::*;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         start = 1'b0;
  logic [255:0] otk = '0;
  logic [31:0]  len_aad = '0;
  logic [31:0]  len_ct = '0;
  logic [127:0] tag;
  logic         done, busy, err;

  aead_mac_fmt_if bus ();

  aead_mac_fmt dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_otk     (otk),
    .i_len_aad (len_aad),
    .i_len_ct  (len_ct),
    .bus       (bus),
    .o_tag     (tag),
    .o_done    (done),
    .o_busy    (busy),
    .o_err     (err)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  logic [7:0]   aad_b[$];
  logic [7:0]   ct_b[$];
  logic [127:0] exp_q[$];
  logic [127:0] up_q[$];
  logic [127:0] en_log[$];
  logic [127:0] exp_r = '0;
  logic [127:0] exp_tag = '0;
  logic [31:0]  exp_len = '0;
  int           exp_n = 0;
  int           up_dly = 1;
  int           en_seen = 0, drdy_cycles = 0, start_seen = 0, done_seen = 0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic fail_line(input string name);
    checks++;
    errors++;
    $display("FAIL %s: DUT event did not occur within its cycle budget", name);
  endtask

  function automatic logic [7:0] seg_byte(input int seg, input int idx);
    if (seg == 0) return aad_b[idx];
    return ct_b[idx];
  endfunction

  task automatic set_data(input int la, input int lc, input logic all_ff);
    aad_b.delete();
    ct_b.delete();
    for (int i = 0; i < la; i++) aad_b.push_back(all_ff ? 8'hFF : 8'(i*3 + 1));
    for (int i = 0; i < lc; i++) ct_b.push_back(all_ff ? 8'hFF : 8'(i*7 + 5));
  endtask

  // Expected MAC stream: s, zero-padded AAD blocks, zero-padded CT blocks, le64 lengths.
  task automatic build_model(input logic [31:0] la, input logic [31:0] lc,
                             input logic [255:0] key, input logic [7:0] fill);
    longint na, nc, n, len, idx;
    logic [127:0] raw, blk;
    exp_q.delete();
    up_q.delete();
    na = (longint'(la) + 15) / 16;
    nc = (longint'(lc) + 15) / 16;
    exp_r = key[127:0];
    exp_q.push_back(key[255:128]);
    for (int seg = 0; seg < 2; seg++) begin
      n   = (seg == 0) ? na : nc;
      len = (seg == 0) ? longint'(la) : longint'(lc);
      for (longint i = 0; i < n; i++) begin
        for (int b = 0; b < 16; b++) begin
          idx = 16*i + b;
          if (idx < len) begin
            raw[8*b +: 8] = seg_byte(seg, int'(idx));
            blk[8*b +: 8] = raw[8*b +: 8];
          end else begin
            raw[8*b +: 8] = fill;
            blk[8*b +: 8] = 8'h00;
          end
        end
        up_q.push_back(raw);
        exp_q.push_back(blk);
      end
    end
    blk = '0;
    for (int b = 0; b < 4; b++) begin
      blk[8*b +: 8]      = 8'(la >> (8*b));
      blk[64 + 8*b +: 8] = 8'(lc >> (8*b));
    end
    exp_q.push_back(blk);
    exp_len = 32'(16 * (na + nc + 1));
    exp_n   = int'(2 + na + nc);
  endtask

  always @(negedge clk) begin
    if (!rst) begin
      if (bus.o_start) begin
        start_seen++;
        chk("start_r", bus.o_msg, exp_r);
        chk("len_msg", bus.o_len_msg, exp_len);
      end
      if (bus.o_en_msg) begin
        en_seen++;
        en_log.push_back(bus.o_msg);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL en_extra: strobe %h with no block expected", bus.o_msg);
        end else begin
          chk("en_blk", bus.o_msg, exp_q.pop_front());
        end
      end
      if (bus.o_drdy) drdy_cycles++;
      if (done) begin
        done_seen++;
        chk("tag", tag, exp_tag);
      end
    end
  end

  // Upstream buffer: answers each o_drdy with i_dvld after up_dly cycles.
  initial begin
    bus.i_dvld = 1'b0;
    bus.i_data = '0;
    forever begin
      @(negedge clk);
      if (bus.o_drdy) begin
        repeat (up_dly - 1) @(negedge clk);
        if (up_q.size() != 0) bus.i_data = up_q.pop_front();
        else bus.i_data = '0;
        bus.i_dvld = 1'b1;
        @(posedge clk);
        #1 bus.i_dvld = 1'b0;
      end
    end
  end

  task automatic start_txn(input logic [31:0] la, input logic [31:0] lc, input logic [255:0] key);
    @(posedge clk);
    #1 otk = key; len_aad = la; len_ct = lc; start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask

  task automatic rqst_pulse();
    @(posedge clk);
    #1 bus.i_rqst_msg = 1'b1;
    @(posedge clk);
    #1 bus.i_rqst_msg = 1'b0;
  endtask

  // Tag-engine emulator: one request per block, optional stray request, then done.
  task automatic ptag_run(input int n_blk, input int extra_at, input logic [127:0] t);
    int to;
    exp_tag = t;
    for (to = 0; to < 50; to++) begin @(negedge clk); if (bus.o_start) break; end
    if (to >= 50) begin fail_line("start_timeout"); return; end
    chk("busy_run", busy, 1);
    for (int k = 0; k < n_blk; k++) begin
      rqst_pulse();
      if (k == extra_at) rqst_pulse();
      for (to = 0; to < 100; to++) begin @(negedge clk); if (bus.o_en_msg) break; end
      if (to >= 100) begin fail_line("en_timeout"); return; end
    end
    repeat (2) @(posedge clk);
    #1 bus.i_tag = t; bus.i_done = 1'b1;
    @(posedge clk);
    #1 bus.i_done = 1'b0;
    for (to = 0; to < 10; to++) begin @(negedge clk); if (done) break; end
    chk("done_lat", to, 0);
  endtask

  task automatic run_txn(input string nm, input logic [31:0] la, input logic [31:0] lc,
                         input logic [255:0] key, input logic [7:0] fill, input int dly,
                         input int extra_at, input logic [127:0] t, input logic exp_err);
    build_model(la, lc, key, fill);
    up_dly = dly;
    en_seen = 0; drdy_cycles = 0; start_seen = 0;
    en_log.delete();
    start_txn(la, lc, key);
    ptag_run(exp_n, extra_at, t);
    @(negedge clk);
    chk({nm, "_pending"}, exp_q.size(), 0);
    chk({nm, "_strobes"}, en_seen, exp_n);
    chk({nm, "_drdy"}, drdy_cycles, (exp_n - 2) * dly);
    chk({nm, "_starts"}, start_seen, 1);
    chk({nm, "_err"}, err, exp_err);
    chk({nm, "_busy"}, busy, 0);
    $display("txn %s: aad=%0d ct=%0d len_msg=%0d strobes=%0d drdy=%0d err=%0b errors=%0d",
             nm, la, lc, bus.o_len_msg, en_seen, drdy_cycles, err, errors);
  endtask

  task automatic chk_all_zero(input string nm);
    chk({nm, "_msg"}, bus.o_msg, 0);
    chk({nm, "_tag"}, tag, 0);
    chk({nm, "_ctl"}, {bus.o_len_msg, bus.o_drdy, bus.o_start, bus.o_en_msg, done, busy, err}, 0);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [255:0] key_rfc, key2;
  logic [95:0]  aad_rfc;
  logic [127:0] b;
  int           to;

  initial begin
    bus.i_rqst_msg = 1'b0;
    bus.i_tag      = '0;
    bus.i_done     = 1'b0;
    key_rfc = {128'hff53d53e_7875932a_ebd97510_73d6e10a, 128'h8455e9a4_557ab609_af47b42d_252bac7b};
    key2    = {128'h0f0e0d0c_0b0a0908_07060504_03020100, 128'h1f1e1d1c_1b1a1918_17161514_13121110};
    aad_rfc = 96'hc7c6c5c4_c3c2c1c0_53525150;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk_all_zero("reset");
    $display("txn reset: outputs after reset checked, errors=%0d", errors);
    #1 rst = 1'b0;

    // RFC 8439 AEAD vector sizes
    set_data(12, 114, 1'b0);
    aad_b.delete();
    for (int i = 0; i < 12; i++) aad_b.push_back(aad_rfc[8*i +: 8]);
    run_txn("rfc", 32'd12, 32'd114, key_rfc, 8'hEE, 2, -1,
            128'h910660d0_cb2e907e_6ae2094f_590be11a, 1'b0);
    chk("rfc_len_msg", bus.o_len_msg, 160);
    b = en_log[1];
    chk("rfc_aad_pad", b[127:96], 0);
    chk("rfc_aad_blk", b, 128'h00000000_c7c6c5c4_c3c2c1c0_53525150);
    b = en_log[en_log.size() - 1];
    chk("rfc_len_blk", b, 128'h00000000_00000072_00000000_0000000c);

    // Empty AAD and CT
    set_data(0, 0, 1'b0);
    run_txn("empty", 32'd0, 32'd0, key2, 8'hEE, 1, -1, 128'h1234, 1'b0);
    chk("empty_len_msg", bus.o_len_msg, 16);
    b = en_log[1];
    chk("empty_len_blk", b, 0);

    // Full blocks only, all-ones data
    set_data(32, 16, 1'b1);
    run_txn("full", 32'd32, 32'd16, key2, 8'hFF, 1, -1, 128'hABCD, 1'b0);
    b = en_log[1];
    chk("full_aad0", b, {128{1'b1}});
    b = en_log[3];
    chk("full_ct0", b, {128{1'b1}});
    b = en_log[4];
    chk("full_len_blk", b, 128'h00000000_00000010_00000000_00000020);

    // One-byte tail with slow upstream
    set_data(0, 17, 1'b1);
    run_txn("tail", 32'd0, 32'd17, key2, 8'hFF, 5, -1, 128'h5555, 1'b0);
    chk("tail_drdy_cycles", drdy_cycles, 10);
    b = en_log[2];
    chk("tail_ct1", b, 128'h000000FF);

    // Stray request while o_drdy is pending
    set_data(20, 40, 1'b0);
    run_txn("stray", 32'd20, 32'd40, key_rfc, 8'h3C, 6, 2, 128'h77, 1'b1);
    chk("stray_err_sticky", err, 1);

    // Next accepted start clears the error
    set_data(5, 1, 1'b0);
    run_txn("clear", 32'd5, 32'd1, key2, 8'h99, 3, -1, 128'h88, 1'b0);

    // Reset in the middle of a CT block
    set_data(0, 64, 1'b0);
    build_model(32'd0, 32'd64, key2, 8'hEE);
    up_dly = 8;
    start_txn(32'd0, 32'd64, key2);
    for (to = 0; to < 50; to++) begin @(negedge clk); if (bus.o_start) break; end
    if (to >= 50) fail_line("rst_start_timeout");
    rqst_pulse();
    rqst_pulse();
    for (to = 0; to < 10; to++) begin @(negedge clk); if (bus.o_drdy) break; end
    chk("rst_drdy_up", bus.o_drdy, 1);
    @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk_all_zero("midrst");
    @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
    done_seen = 0;
    repeat (20) @(negedge clk);
    chk("midrst_no_done", done_seen, 0);
    $display("txn midrst: reset during CT block, errors=%0d", errors);

    set_data(5, 33, 1'b0);
    run_txn("after_rst", 32'd5, 32'd33, key_rfc, 8'h11, 2, -1, 128'h99, 1'b0);

    // Length overflow
    start_seen = 0;
    start_txn(32'hFFFFFFFF, 32'hFFFFFFFF, key2);
    repeat (10) @(negedge clk);
    chk("ovf_err", err, 1);
    chk("ovf_nostart", start_seen, 0);
    chk("ovf_busy", busy, 0);
    chk("ovf_len_hold", bus.o_len_msg, exp_len);
    $display("txn ovf: aad=ffffffff ct=ffffffff err=%0b busy=%0b errors=%0d", err, busy, errors);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
